dbus_bridge: RTL and testbench
==============================

// Module: dbus_bridge
// PURPOSE
//  Upstream stage of peripheral_block: sits between the core LSU data port and the peripheral bus.
//  Forwards one transaction at a time, decodes the peripheral window and rejects misaligned accesses.
//  Also rejects unmapped accesses, with an error response the core can trap on.
//  Times out peripherals that grant but never return rvalid.
// PARAMETERS
//  PERIPH_BASE  32'h1000_0000  base of the peripheral address window
//  PERIPH_MASK  32'hF000_0000  address bits compared against PERIPH_BASE
//  TIMEOUT      16             max cycles from downstream gnt to rvalid before error (>=2)
// PORTS
//  clk          in   1   single clock
//  rst          in   1   asynchronous reset, active-high
//  core_req     in   1   core request; core_we, core_be, core_addr and core_wdata are valid when set
//  core_we      in   1   1 = write
//  core_be      in   4   byte enables
//  core_addr    in   32  byte address
//  core_wdata   in   32  write data
//  core_gnt     out  1   request accepted this cycle
//  core_rvalid  out  1   response valid (one pulse per granted request)
//  core_rdata   out  32  read data, 0 on error or write
//  core_err     out  1   error qualifier, valid with core_rvalid
//  data_req     out  1   to peripheral_block; data_we, data_be, data_addr, data_wdata follow
//  data_we      out  1   to peripheral_block
//  data_be      out  4   to peripheral_block
//  data_addr    out  32  to peripheral_block
//  data_wdata   out  32  to peripheral_block
//  data_gnt     in   1   from peripheral_block
//  data_rvalid  in   1   from peripheral_block
//  data_rdata   in   32  from peripheral_block
//  data_err     in   1   from peripheral_block
//  err_count    out  8   saturating count of error responses issued
// BEHAVIOUR
//  - Reset: state=IDLE; core_gnt, core_rvalid, core_err and data_req are 0; core_rdata=0; err_count=0.
//  - Decode is combinational on core_addr.
//    hit = (core_addr & PERIPH_MASK) == PERIPH_BASE.
//    bad_align = be not in {0001,0010,0100,1000,0011,1100,1111}, or be==0011/1100 with addr[0]!=0, or be==1111 with addr[1:0]!=0.
//  - IDLE, core_req=1, hit and aligned:
//    - data_req=1, passed through from core_req in the same cycle; data_* = core_* (combinational, 0 latency).
//    - core_gnt = data_gnt. On gnt -> WAIT_RSP, timer cleared.
//  - IDLE, core_req=1, miss or bad_align:
//    - data_req stays 0; core_gnt=1 in the same cycle -> ERR_RSP.
//  - ERR_RSP: core_rvalid=1, core_err=1, core_rdata=0 for exactly one cycle; err_count++; -> IDLE.
//  - WAIT_RSP:
//    - data_req=0 and core_gnt=0; new core requests are stalled.
//    - Timer increments each cycle.
//    - On data_rvalid: core_rvalid=1 in the same cycle (combinational); core_rdata=data_rdata; core_err=data_err.
//      If data_err, err_count++. -> IDLE.
//    - If the timer reaches TIMEOUT-1 without data_rvalid: core_rvalid=1, core_err=1, core_rdata=0, err_count++.
//      Then -> IDLE.
//  - A late data_rvalid arriving in IDLE is ignored; no core_rvalid is generated.
//  - A data_rvalid and the timeout in the same cycle: rvalid wins, and no timeout error is issued.
//  - Back-to-back: the IDLE cycle following a response may accept a new request; sustained rate is 1 per 2 cycles.
//  - err_count saturates at 8'hFF and never wraps.
//  - Reset asserted mid-transaction:
//    - Immediate return to IDLE with all outputs at reset values.
//    - The pending core response is dropped; the core is reset alongside the bridge.
//  - core_rdata is 0 whenever core_rvalid=0.
//  - Exactly one core_rvalid per core_gnt; never two.
// STRUCTURE
//  - Shared package dbus_pkg:
//    - typedef enum logic [1:0] {BR_IDLE, BR_WAIT_RSP, BR_ERR_RSP} bridge_state_t.
//    - be_legal() alignment-check function, shared with future bus masters.
//  - One sub-module: dbus_timeout_timer (clear, enable, expire output; width $clog2(TIMEOUT)+1).
//  - Everything else is in one module: the FSM, decode and the error counter.
// TESTING
//  1. Read 0x1000_0004, be=1111; peripheral gnt at cycle 0, rvalid at cycle 1 with rdata=0xDEADBEEF.
//     -> core_gnt at cycle 0; core_rvalid at cycle 1 with rdata=0xDEADBEEF, err=0; err_count=0.
//  2. Write 0x2000_0000 (unmapped).
//     -> data_req never asserts; core_gnt at cycle 0; core_rvalid+err at cycle 1 with rdata=0; err_count=1.
//  3. Read 0x1000_0002 with be=1111 (misaligned).
//     -> error response as in test 2; data_req stays 0.
//  4. Peripheral grants but never returns rvalid (TIMEOUT=16).
//     -> core_rvalid+err exactly 16 cycles after gnt.
//     -> A data_rvalid injected afterwards produces no core_rvalid.
//  5. Second core_req held during WAIT_RSP.
//     -> core_gnt stays 0 until the cycle after the first response; exactly one rvalid per gnt.
//  6. 300 unmapped accesses -> err_count saturates at 0xFF.
//     Assert rst during WAIT_RSP -> all outputs 0 immediately; state IDLE.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared definitions for the core data-bus path.
//   bridge_state_t : dbus_bridge FSM encoding
//   be_legal()     : byte-enable / address alignment check, reusable by any bus master
package dbus_pkg;

  typedef enum logic [1:0] {
    BR_IDLE     = 2'd0,
    BR_WAIT_RSP = 2'd1,
    BR_ERR_RSP  = 2'd2
  } bridge_state_t;

  localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

  // Legal: single bytes anywhere, halfwords on even addresses, words on word addresses.
  function automatic logic be_legal(input logic [3:0] be, input logic [1:0] addr_lo);
    logic ok;
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
      4'b0011, 4'b1100:                   ok = (addr_lo[0] == 1'b0);
      4'b1111:                            ok = (addr_lo == 2'b00);
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dbus_timeout_timer.sv
// Response timeout timer.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : zero the count (takes priority over enable)
//   enable   : count up one per cycle, holding once expired
//   expire   : count has reached TIMEOUT-1
module dbus_timeout_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT) + 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q;

  assign expire = (count_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expire) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/dbus_bridge.sv
// Bridge between the core LSU data port and the peripheral bus.
// Forwards one transaction at a time, answers unmapped or misaligned accesses locally with an
// error response, and times out peripherals that grant but never respond.
//   clk, rst              : clock, asynchronous active-high reset
//   core_req/we/be/addr/wdata, core_gnt/rvalid/rdata/err : core side
//   data_req/we/be/addr/wdata, data_gnt/rvalid/rdata/err : peripheral side
//   err_count             : saturating count of error responses issued to the core
module dbus_bridge
  import dbus_pkg::*;
#(
  parameter logic [31:0] PERIPH_BASE = 32'h1000_0000,
  parameter logic [31:0] PERIPH_MASK = 32'hF000_0000,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [3:0]  core_be,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic        data_req,
  output logic        data_we,
  output logic [3:0]  data_be,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_gnt,
  input  logic        data_rvalid,
  input  logic [31:0] data_rdata,
  input  logic        data_err,
  output logic [7:0]  err_count
);

  bridge_state_t state_q;
  logic          we_q;
  logic [7:0]    err_count_q;

  logic hit, legal, fwd;
  logic err_inc;
  logic timer_clear, timer_en, timer_expire;

  assign hit   = ((core_addr & PERIPH_MASK) == PERIPH_BASE);
  assign legal = be_legal(core_be, core_addr[1:0]);
  assign fwd   = hit && legal;

  // Attributes ride straight through; only data_req is qualified.
  assign data_we    = core_we;
  assign data_be    = core_be;
  assign data_addr  = core_addr;
  assign data_wdata = core_wdata;

  assign err_count = err_count_q;

  dbus_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .expire (timer_expire)
  );

  // Outputs are forced low during reset so a core still driving req sees nothing.
  always_comb begin
    data_req    = 1'b0;
    core_gnt    = 1'b0;
    core_rvalid = 1'b0;
    core_err    = 1'b0;
    core_rdata  = '0;
    err_inc     = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        BR_IDLE: begin
          if (core_req) begin
            if (fwd) begin
              data_req    = 1'b1;
              core_gnt    = data_gnt;
              timer_clear = data_gnt;
            end else begin
              core_gnt = 1'b1;
            end
          end
        end
        BR_WAIT_RSP: begin
          timer_en = 1'b1;
          // A response arriving on the expiry cycle wins over the timeout.
          if (data_rvalid) begin
            core_rvalid = 1'b1;
            core_err    = data_err;
            core_rdata  = (data_err || we_q) ? '0 : data_rdata;
            err_inc     = data_err;
          end else if (timer_expire) begin
            core_rvalid = 1'b1;
            core_err    = 1'b1;
            err_inc     = 1'b1;
          end
        end
        BR_ERR_RSP: begin
          core_rvalid = 1'b1;
          core_err    = 1'b1;
          err_inc     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BR_IDLE;
      we_q        <= 1'b0;
      err_count_q <= '0;
    end else begin
      unique case (state_q)
        BR_IDLE: begin
          if (core_gnt) begin
            state_q <= fwd ? BR_WAIT_RSP : BR_ERR_RSP;
            we_q    <= core_we;
          end
        end
        BR_WAIT_RSP: begin
          if (core_rvalid) state_q <= BR_IDLE;
        end
        BR_ERR_RSP: state_q <= BR_IDLE;
        default:    state_q <= BR_IDLE;
      endcase
      if (err_inc && (err_count_q != ERR_COUNT_MAX)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dbus_bridge.sv
module tb_dbus_bridge;
  import dbus_pkg::*;

  logic        clk, rst;
  logic        core_req, core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr, core_wdata;
  logic        core_gnt, core_rvalid, core_err;
  logic [31:0] core_rdata;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;
  int gnt_cnt  = 0;
  int rv_cnt   = 0;
  int exp_err  = 0;

  dbus_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_be     (core_be),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .core_err    (core_err),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_be     (data_be),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .data_err    (data_err),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      gnt_cnt = gnt_cnt + int'(core_gnt);
      rv_cnt  = rv_cnt + int'(core_rvalid);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic gnt,
                       input logic rv, input logic [31:0] rdata, input logic err);
    core_req = req; core_we = we; core_be = be; core_addr = addr; core_wdata = wdata;
    data_gnt = gnt; data_rvalid = rv; data_rdata = rdata; data_err = err;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  // be / address-offset table for the alignment check
  logic [3:0] tbl_be    [7] = '{4'b0001, 4'b0011, 4'b0011, 4'b1100, 4'b0101, 4'b0000, 4'b1111};
  logic [1:0] tbl_lo    [7] = '{2'd3,    2'd2,    2'd1,    2'd2,    2'd0,    2'd0,    2'd0};
  logic       tbl_legal [7] = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b0,    1'b0,    1'b1};

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    check_eq("rst_gnt",    32'(core_gnt),    32'd0);
    check_eq("rst_rvalid", 32'(core_rvalid), 32'd0);
    check_eq("rst_err",    32'(core_err),    32'd0);
    check_eq("rst_dreq",   32'(data_req),    32'd0);
    check_eq("rst_rdata",  core_rdata,       32'd0);
    check_eq("rst_ecnt",   32'(err_count),   32'd0);
    check_eq("rst_state",  32'(dut.state_q), 32'(BR_IDLE));
    tick(); rst = 1'b0; idle();

    // 1: mapped read
    tick(); drive(1, 0, 4'hF, 32'h1000_0004, 32'h0, 1, 0, 32'h0, 0);
    @(negedge clk);
    check_eq("t1_dreq",  32'(data_req), 32'd1);
    check_eq("t1_daddr", data_addr,     32'h1000_0004);
    check_eq("t1_gnt",   32'(core_gnt), 32'd1);
    check_eq("t1_rv0",   32'(core_rvalid), 32'd0);
    tick(); drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    check_eq("t1_rv",    32'(core_rvalid), 32'd1);
    check_eq("t1_rdata", core_rdata,       32'hDEAD_BEEF);
    check_eq("t1_err",   32'(core_err),    32'd0);
    tick(); idle(); @(negedge clk);
    check_eq("t1_ecnt",  32'(err_count),   32'd0);
    check_eq("t1_rvoff", 32'(core_rvalid), 32'd0);

    // 2: unmapped write; 3: misaligned read
    for (int t = 0; t < 2; t++) begin
      tick();
      if (t == 0) drive(1, 1, 4'hF, 32'h2000_0000, 32'h1234_5678, 1, 0, 32'h0, 0);
      else        drive(1, 0, 4'hF, 32'h1000_0002, 32'h0, 1, 0, 32'h0, 0);
      @(negedge clk);
      check_eq("t23_dreq", 32'(data_req),    32'd0);
      check_eq("t23_gnt",  32'(core_gnt),    32'd1);
      check_eq("t23_rv0",  32'(core_rvalid), 32'd0);
      tick(); drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'hFFFF_FFFF, 0);
      @(negedge clk);
      check_eq("t23_rv",    32'(core_rvalid), 32'd1);
      check_eq("t23_err",   32'(core_err),    32'd1);
      check_eq("t23_rdata", core_rdata,       32'd0);
      check_eq("t23_dreq1", 32'(data_req),    32'd0);
      bump_err();
      tick(); idle(); @(negedge clk);
      check_eq("t23_ecnt", 32'(err_count), 32'(exp_err));
    end

    // 4: timeout 16 cycles after gnt, then a late rvalid; 4b: rvalid on the expiry cycle
    for (int t = 0; t < 2; t++) begin
      tick(); drive(1, 0, 4'hF, 32'h1000_0008, 32'h0, 1, 0, 32'h0, 0);
      @(negedge clk);
      check_eq("t4_gnt", 32'(core_gnt), 32'd1);
      for (int k = 1; k <= 16; k++) begin
        tick(); idle();
        if (t == 1 && k == 16) drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0000_600D, 0);
        @(negedge clk);
        if (k < 16) begin
          check_eq("t4_quiet", 32'(core_rvalid), 32'd0);
        end else begin
          check_eq("t4_rv",    32'(core_rvalid), 32'd1);
          check_eq("t4_err",   32'(core_err),    32'(t == 0));
          check_eq("t4_rdata", core_rdata,       (t == 0) ? 32'h0 : 32'h0000_600D);
        end
      end
      if (t == 0) bump_err();
      tick(); drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0000_1234, 1);
      @(negedge clk);
      check_eq("t4_late_rv",    32'(core_rvalid), 32'd0);
      check_eq("t4_late_rdata", core_rdata,       32'd0);
      check_eq("t4_ecnt",       32'(err_count),   32'(exp_err));
    end

    // 5: second request held through WAIT_RSP
    tick(); drive(1, 0, 4'b0011, 32'h1000_0010, 32'h0, 1, 0, 32'h0, 0);
    @(negedge clk);
    check_eq("t5_gnt_a", 32'(core_gnt), 32'd1);
    tick(); drive(1, 1, 4'b1100, 32'h1000_0016, 32'hCAFE_F00D, 1, 0, 32'h0, 0);
    @(negedge clk);
    check_eq("t5_stall_gnt",  32'(core_gnt), 32'd0);
    check_eq("t5_stall_dreq", 32'(data_req), 32'd0);
    tick(); drive(1, 1, 4'b1100, 32'h1000_0016, 32'hCAFE_F00D, 1, 1, 32'hAAAA_5555, 0);
    @(negedge clk);
    check_eq("t5_rv_a",    32'(core_rvalid), 32'd1);
    check_eq("t5_rdata_a", core_rdata,       32'hAAAA_5555);
    check_eq("t5_gnt_hold", 32'(core_gnt),   32'd0);
    tick(); drive(1, 1, 4'b1100, 32'h1000_0016, 32'hCAFE_F00D, 1, 0, 32'h0, 0);
    @(negedge clk);
    check_eq("t5_gnt_b",   32'(core_gnt),    32'd1);
    check_eq("t5_dreq_b",  32'(data_req),    32'd1);
    check_eq("t5_dwe_b",   32'(data_we),     32'd1);
    check_eq("t5_dbe_b",   32'(data_be),     32'hC);
    check_eq("t5_dwd_b",   data_wdata,       32'hCAFE_F00D);
    check_eq("t5_rv_off",  32'(core_rvalid), 32'd0);
    tick(); drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0, 1);
    @(negedge clk);
    check_eq("t5_rv_b",  32'(core_rvalid), 32'd1);
    check_eq("t5_err_b", 32'(core_err),    32'd1);
    bump_err();
    tick(); idle(); @(negedge clk);
    check_eq("t5_ecnt", 32'(err_count), 32'(exp_err));

    // alignment table
    for (int i = 0; i < 7; i++) begin
      tick(); drive(1, 0, tbl_be[i], {30'h0400_0000, tbl_lo[i]}, 32'h0, 0, 0, 32'h0, 0);
      @(negedge clk);
      check_eq($sformatf("al%0d_dreq", i), 32'(data_req), 32'(tbl_legal[i]));
      check_eq($sformatf("al%0d_gnt", i),  32'(core_gnt), 32'(!tbl_legal[i]));
      tick(); idle(); @(negedge clk);
      check_eq($sformatf("al%0d_rv", i), 32'(core_rvalid), 32'(!tbl_legal[i]));
      if (!tbl_legal[i]) bump_err();
    end

    check_eq("gnt_rv_pairs", 32'(rv_cnt), 32'(gnt_cnt));

    // 6: saturation
    for (int i = 0; i < 300; i++) begin
      tick(); drive(1, 0, 4'hF, 32'h3000_0000, 32'h0, 0, 0, 32'h0, 0);
      tick(); idle();
      bump_err();
    end
    tick(); @(negedge clk);
    check_eq("t6_sat", 32'(err_count), 32'(exp_err));

    // reset asserted during WAIT_RSP
    tick(); drive(1, 0, 4'hF, 32'h1000_0020, 32'h0, 1, 0, 32'h0, 0);
    @(negedge clk);
    check_eq("t6_gnt", 32'(core_gnt), 32'd1);
    tick(); drive(1, 0, 4'hF, 32'h1000_0024, 32'h0, 1, 1, 32'h5555_AAAA, 0);
    #1 rst = 1'b1;
    #1;
    check_eq("mr_gnt",    32'(core_gnt),    32'd0);
    check_eq("mr_rvalid", 32'(core_rvalid), 32'd0);
    check_eq("mr_err",    32'(core_err),    32'd0);
    check_eq("mr_rdata",  core_rdata,       32'd0);
    check_eq("mr_dreq",   32'(data_req),    32'd0);
    check_eq("mr_ecnt",   32'(err_count),   32'd0);
    check_eq("mr_state",  32'(dut.state_q), 32'(BR_IDLE));
    idle();
    tick(); rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
